// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 parallel-input front end.
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_PAD     = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DROP    = 2'd3
    } padder_state_t;

    localparam logic [7:0]  SHA256_PAD_BYTE  = 8'h80;
    localparam int unsigned SHA256_PIF_WORDS = 15;
    localparam int unsigned SHA256_PIF_BYTES = SHA256_PIF_WORDS * 4;

    // Number of valid byte lanes in a beat.
    function automatic logic [2:0] keep_count(input logic [3:0] keep);
        keep_count = 3'(keep[0]) + 3'(keep[1]) + 3'(keep[2]) + 3'(keep[3]);
    endfunction

endpackage

// File: rtl/sha256_axis_padder.sv
// Packs an AXI4-Stream byte message big-endian into one padded block and
// hands it to sha256_core_pif over the string_dv/string_ready handshake.
module sha256_axis_padder
    import sha256_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 31
) (
    input  logic        m_axis_aclk,
    input  logic        m_axis_aresetn,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [31:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    output logic [31:0] string_w0,
    output logic [31:0] string_w1,
    output logic [31:0] string_w2,
    output logic [31:0] string_w3,
    output logic [31:0] string_w4,
    output logic [31:0] string_w5,
    output logic [31:0] string_w6,
    output logic [31:0] string_w7,
    output logic [31:0] string_w8,
    output logic [31:0] string_w9,
    output logic [31:0] string_w10,
    output logic [31:0] string_w11,
    output logic [31:0] string_w12,
    output logic [31:0] string_w13,
    output logic [31:0] string_w14,
    output logic [7:0]  string_size,
    output logic        string_dv,
    input  logic        string_ready,
    output logic        overflow
);

    localparam int unsigned CNT_W = 6;

    padder_state_t    r_state;
    padder_state_t    w_next;
    logic [7:0]       r_buf [SHA256_PIF_BYTES];
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_size;
    logic             r_tready;
    logic             r_dv;
    logic             r_overflow;

    logic             w_accept;
    logic             w_handshake;
    logic [2:0]       w_nbytes;
    logic [CNT_W-1:0] w_total;
    logic             w_too_long;
    logic             w_store;
    logic             w_pad;
    logic             w_clear;
    logic             w_ovf;
    logic [31:0]      w_words [SHA256_PIF_WORDS];

    assign w_accept    = s_axis_tvalid & r_tready;
    assign w_handshake = r_dv & string_ready;
    assign w_nbytes    = keep_count(s_axis_tkeep);
    assign w_total     = r_count + CNT_W'(w_nbytes);
    assign w_too_long  = w_total > CNT_W'(MAX_BYTES);

    // State register.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) r_state <= ST_COLLECT;
        else                 r_state <= w_next;
    end

    // Next state and datapath strobes.
    always_comb begin
        w_next  = r_state;
        w_store = 1'b0;
        w_pad   = 1'b0;
        w_clear = 1'b0;
        w_ovf   = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                if (w_accept) begin
                    if (w_too_long) begin
                        w_ovf   = 1'b1;
                        w_clear = 1'b1;
                        w_next  = s_axis_tlast ? ST_COLLECT : ST_DROP;
                    end else begin
                        w_store = 1'b1;
                        if (s_axis_tlast) w_next = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                w_pad  = 1'b1;
                w_next = ST_PRESENT;
            end
            ST_PRESENT: begin
                // string_ready only counts once string_dv is visible
                if (w_handshake) begin
                    w_clear = 1'b1;
                    w_next  = ST_COLLECT;
                end
            end
            ST_DROP: begin
                if (w_accept && s_axis_tlast) w_next = ST_COLLECT;
            end
            default: w_next = ST_COLLECT;
        endcase
    end

    // Registered handshake/status outputs decoded from the next state.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            r_tready   <= 1'b0;
            r_dv       <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_tready   <= (w_next == ST_COLLECT) || (w_next == ST_DROP);
            r_dv       <= (r_state == ST_PRESENT) && (w_next == ST_PRESENT);
            r_overflow <= w_ovf;
        end
    end

    // Byte buffer, byte count and bit length.
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            for (int i = 0; i < int'(SHA256_PIF_BYTES); i++) r_buf[i] <= 8'h00;
            r_count <= '0;
            r_size  <= 8'h00;
        end else if (w_clear) begin
            for (int i = 0; i < int'(SHA256_PIF_BYTES); i++) r_buf[i] <= 8'h00;
            r_count <= '0;
            r_size  <= 8'h00;
        end else if (w_store) begin
            for (int j = 0; j < 4; j++) begin
                if (s_axis_tkeep[j]) r_buf[r_count + CNT_W'(j)] <= s_axis_tdata[8*j +: 8];
            end
            r_count <= w_total;
        end else if (w_pad) begin
            r_buf[r_count] <= SHA256_PAD_BYTE;
            r_size         <= 8'({r_count, 3'b000});
        end
    end

    // Big-endian word view of the buffer.
    always_comb begin
        for (int i = 0; i < int'(SHA256_PIF_WORDS); i++) begin
            w_words[i] = {r_buf[4*i], r_buf[4*i+1], r_buf[4*i+2], r_buf[4*i+3]};
        end
    end

    assign s_axis_tready = r_tready;
    assign string_dv     = r_dv;
    assign overflow      = r_overflow;
    assign string_size   = r_size;
    assign string_w0     = w_words[0];
    assign string_w1     = w_words[1];
    assign string_w2     = w_words[2];
    assign string_w3     = w_words[3];
    assign string_w4     = w_words[4];
    assign string_w5     = w_words[5];
    assign string_w6     = w_words[6];
    assign string_w7     = w_words[7];
    assign string_w8     = w_words[8];
    assign string_w9     = w_words[9];
    assign string_w10    = w_words[10];
    assign string_w11    = w_words[11];
    assign string_w12    = w_words[12];
    assign string_w13    = w_words[13];
    assign string_w14    = w_words[14];

endmodule

// File: tb/tb_sha256_axis_padder.sv
// Directed, table-driven bench for sha256_axis_padder.
module tb_sha256_axis_padder;

    typedef struct packed {
        logic [3:0]        nbeats;
        logic [7:0][31:0]  data;
        logic [7:0][3:0]   keep;
        logic              exp_ovf;
        logic [7:0]        exp_size;
        logic [14:0][31:0] exp_w;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic [31:0] w_act [15];
    logic [31:0] sw0, sw1, sw2, sw3, sw4, sw5, sw6, sw7;
    logic [31:0] sw8, sw9, sw10, sw11, sw12, sw13, sw14;
    logic [7:0]  string_size;
    logic        string_dv;
    logic        string_ready;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;
    vec_t vecs [5];

    always #5 clk = ~clk;

    sha256_axis_padder #(.MAX_BYTES(31)) dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetn (rst_n),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tlast   (s_axis_tlast),
        .string_w0      (sw0),
        .string_w1      (sw1),
        .string_w2      (sw2),
        .string_w3      (sw3),
        .string_w4      (sw4),
        .string_w5      (sw5),
        .string_w6      (sw6),
        .string_w7      (sw7),
        .string_w8      (sw8),
        .string_w9      (sw9),
        .string_w10     (sw10),
        .string_w11     (sw11),
        .string_w12     (sw12),
        .string_w13     (sw13),
        .string_w14     (sw14),
        .string_size    (string_size),
        .string_dv      (string_dv),
        .string_ready   (string_ready),
        .overflow       (overflow)
    );

    always_comb begin
        w_act[0]  = sw0;  w_act[1]  = sw1;  w_act[2]  = sw2;  w_act[3]  = sw3;
        w_act[4]  = sw4;  w_act[5]  = sw5;  w_act[6]  = sw6;  w_act[7]  = sw7;
        w_act[8]  = sw8;  w_act[9]  = sw9;  w_act[10] = sw10; w_act[11] = sw11;
        w_act[12] = sw12; w_act[13] = sw13; w_act[14] = sw14;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_dv"}, 32'(string_dv), 32'd0);
        chk({tag, "_size"}, 32'(string_size), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow), 32'd0);
        for (int i = 0; i < 15; i++) chk($sformatf("%s_w%0d", tag, i), w_act[i], 32'd0);
    endtask

    // Drive one beat from a negedge; returns at the negedge after acceptance.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        for (int t = 0; t < 20 && !s_axis_tready; t++) @(negedge clk);
        if (!s_axis_tready) chk("tready_wait", 32'(s_axis_tready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        for (int b = 0; b < int'(v.nbeats); b++)
            send_beat(v.data[b], v.keep[b], b == int'(v.nbeats) - 1);
        if (v.exp_ovf) begin
            chk({tag, "_ovf_pulse"}, 32'(overflow), 32'd1);
            @(negedge clk);
            chk({tag, "_ovf_drop"}, 32'(overflow), 32'd0);
            repeat (4) begin
                chk({tag, "_no_dv"}, 32'(string_dv), 32'd0);
                chk({tag, "_tready"}, 32'(s_axis_tready), 32'd1);
                @(negedge clk);
            end
            return;
        end
        chk({tag, "_dv_n1"}, 32'(string_dv), 32'd0);
        chk({tag, "_tready_pad"}, 32'(s_axis_tready), 32'd0);
        @(negedge clk);
        chk({tag, "_dv_n2"}, 32'(string_dv), 32'd0);
        @(negedge clk);
        chk({tag, "_dv_n3"}, 32'(string_dv), 32'd1);
        chk({tag, "_size"}, 32'(string_size), 32'(v.exp_size));
        for (int i = 0; i < 15; i++) chk($sformatf("%s_w%0d", tag, i), w_act[i], v.exp_w[i]);
        repeat (5) begin
            @(negedge clk);
            chk({tag, "_hold_dv"}, 32'(string_dv), 32'd1);
            chk({tag, "_hold_tready"}, 32'(s_axis_tready), 32'd0);
            chk({tag, "_hold_size"}, 32'(string_size), 32'(v.exp_size));
            chk({tag, "_hold_w0"}, w_act[0], v.exp_w[0]);
        end
        string_ready = 1'b1;
        @(negedge clk);
        string_ready = 1'b0;
        chk({tag, "_post_tready"}, 32'(s_axis_tready), 32'd1);
        chk_idle({tag, "_post"});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // adios, one byte per beat
        vecs[0] = '0;
        vecs[0].nbeats = 4'd5;
        vecs[0].data[0] = 32'h61; vecs[0].data[1] = 32'h64; vecs[0].data[2] = 32'h69;
        vecs[0].data[3] = 32'h6f; vecs[0].data[4] = 32'h73;
        for (int b = 0; b < 5; b++) vecs[0].keep[b] = 4'b0001;
        vecs[0].exp_size = 8'd40;
        vecs[0].exp_w[0] = 32'h6164696f; vecs[0].exp_w[1] = 32'h73800000;
        // hola caracola
        vecs[1] = '0;
        vecs[1].nbeats = 4'd4;
        vecs[1].data[0] = 32'h616c6f68; vecs[1].data[1] = 32'h72616320;
        vecs[1].data[2] = 32'h6c6f6361; vecs[1].data[3] = 32'h00000061;
        vecs[1].keep[0] = 4'hf; vecs[1].keep[1] = 4'hf; vecs[1].keep[2] = 4'hf;
        vecs[1].keep[3] = 4'b0001;
        vecs[1].exp_size = 8'd104;
        vecs[1].exp_w[0] = 32'h686f6c61; vecs[1].exp_w[1] = 32'h20636172;
        vecs[1].exp_w[2] = 32'h61636f6c; vecs[1].exp_w[3] = 32'h61800000;
        // zero-length
        vecs[2] = '0;
        vecs[2].nbeats = 4'd1;
        vecs[2].keep[0] = 4'b0000;
        vecs[2].exp_size = 8'd0;
        vecs[2].exp_w[0] = 32'h80000000;
        // 31 bytes, byte k = k
        vecs[3] = '0;
        vecs[3].nbeats = 4'd8;
        vecs[3].data[0] = 32'h03020100; vecs[3].data[1] = 32'h07060504;
        vecs[3].data[2] = 32'h0b0a0908; vecs[3].data[3] = 32'h0f0e0d0c;
        vecs[3].data[4] = 32'h13121110; vecs[3].data[5] = 32'h17161514;
        vecs[3].data[6] = 32'h1b1a1918; vecs[3].data[7] = 32'h001e1d1c;
        for (int b = 0; b < 7; b++) vecs[3].keep[b] = 4'hf;
        vecs[3].keep[7] = 4'b0111;
        vecs[3].exp_size = 8'd248;
        vecs[3].exp_w[0] = 32'h00010203; vecs[3].exp_w[1] = 32'h04050607;
        vecs[3].exp_w[2] = 32'h08090a0b; vecs[3].exp_w[3] = 32'h0c0d0e0f;
        vecs[3].exp_w[4] = 32'h10111213; vecs[3].exp_w[5] = 32'h14151617;
        vecs[3].exp_w[6] = 32'h18191a1b; vecs[3].exp_w[7] = 32'h1c1d1e80;
        // 32 bytes: overflow on 8th beat, tlast there
        vecs[4] = vecs[3];
        vecs[4].data[7] = 32'h1f1e1d1c;
        vecs[4].keep[7] = 4'hf;
        vecs[4].exp_ovf = 1'b1;
        vecs[4].exp_size = 8'd0;
        vecs[4].exp_w = '0;

        rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
        s_axis_tlast = 1'b0;
        string_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        chk_idle("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rel_tready", 32'(s_axis_tready), 32'd1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
        run_vec(vecs[0], "adios_after_ovf");

        // Overflow without tlast: DROP until tlast, then a clean message.
        for (int b = 0; b < 8; b++) send_beat(32'hdeadbeef, 4'hf, 1'b0);
        chk("drop_ovf_pulse", 32'(overflow), 32'd1);
        send_beat(32'h12345678, 4'hf, 1'b0);
        chk("drop_ovf_clear", 32'(overflow), 32'd0);
        chk("drop_tready", 32'(s_axis_tready), 32'd1);
        send_beat(32'h12345678, 4'hf, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("drop_no_dv", 32'(string_dv), 32'd0);
        end
        run_vec(vecs[0], "adios_after_drop");

        // Reset mid-message.
        send_beat(vecs[1].data[0], 4'hf, 1'b0);
        send_beat(vecs[1].data[1], 4'hf, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_tready", 32'(s_axis_tready), 32'd0);
        chk_idle("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(vecs[0], "adios_after_rst");

        // Reset while presenting.
        for (int b = 0; b < 5; b++) send_beat(vecs[0].data[b], 4'b0001, b == 4);
        repeat (3) @(negedge clk);
        chk("present_dv", 32'(string_dv), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_idle("presrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(vecs[1], "hola_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
